// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller: ID/EX operand info and branch/mul-div events in, stall/bubble/flush controls out.
// master = pipeline datapath, slave = pipeline_hazard_ctrl.
interface pipeline_hazard_ctrl_if #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
);
   logic [REG_W-1:0] rs1_ID;
   logic [REG_W-1:0] rs2_ID;
   logic             rs1_used_ID;
   logic             rs2_used_ID;
   logic [REG_W-1:0] rd_EX;
   logic             reg_WB_EX;
   logic             load_EX;
   logic             branch_ID;
   logic             branch_resolved;
   logic             branch_taken;
   logic             md_start_EX;
   logic             md_done;
   logic             stall_IFID;
   logic             stall_IDEX;
   logic             stall_EXMEM;
   logic             bubble_EX;
   logic             flush;
   logic             busy;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      output rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rd_EX, reg_WB_EX, load_EX,
             branch_ID, branch_resolved, branch_taken, md_start_EX, md_done,
      input  stall_IFID, stall_IDEX, stall_EXMEM, bubble_EX, flush, busy, stall_cycles
   );

   modport slave (
      input  rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rd_EX, reg_WB_EX, load_EX,
             branch_ID, branch_resolved, branch_taken, md_start_EX, md_done,
      output stall_IFID, stall_IDEX, stall_EXMEM, bubble_EX, flush, busy, stall_cycles
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Sequential hazard controller: load-use stalls, branch wait/flush, optional mul/div busy stall, saturating stall counter.
// Define HAZARD_MULDIV_EN to enable the MD_BUSY stall; otherwise md_start_EX/md_done are ignored and stall_EXMEM is 0.
module pipeline_hazard_ctrl #(
   parameter int REG_W      = 5,
   parameter int LOAD_STALL = 1,
   parameter int FLUSH_LEN  = 1,
   parameter int CNT_W      = 16
) (
   input logic                  clk,
   input logic                  reset,
   pipeline_hazard_ctrl_if.slave hif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_STALL,
      S_BR_WAIT,
      S_FLUSH,
      S_MD_BUSY
   } state_e;

   state_e           state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0] stallCycles_q;

   logic [REG_W-1:0] rdEx;
   logic             luh;
   logic             mdReq;
   logic             stallIfid;
   logic             stallIdex;
   logic             stallExmem;
   logic             bubbleEx;
   logic             flushSig;

   assign rdEx = hif.rd_EX;
   assign luh  = hif.load_EX & hif.reg_WB_EX & (rdEx != '0) &
                 ((hif.rs1_used_ID & (hif.rs1_ID == rdEx)) |
                  (hif.rs2_used_ID & (hif.rs2_ID == rdEx)));

`ifdef HAZARD_MULDIV_EN
   assign mdReq = hif.md_start_EX & ~hif.md_done;
`else
   logic unusedMd;
   assign mdReq    = 1'b0;
   assign unusedMd = hif.md_start_EX ^ hif.md_done ^ stallExmem;
`endif

   // The first cycle of every hazard is answered combinationally from IDLE; later cycles follow cnt_q.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      stallIfid  = 1'b0;
      stallIdex  = 1'b0;
      stallExmem = 1'b0;
      bubbleEx   = 1'b0;
      flushSig   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (mdReq) begin
               stallIfid  = 1'b1;
               stallIdex  = 1'b1;
               stallExmem = 1'b1;
               state_d    = S_MD_BUSY;
            end else if (luh) begin
               stallIfid = 1'b1;
               stallIdex = 1'b1;
               bubbleEx  = 1'b1;
               if (LOAD_STALL > 1) begin
                  state_d = S_LOAD_STALL;
                  cnt_d   = 3'(LOAD_STALL - 1);
               end
            end else if (hif.branch_ID) begin
               stallIfid = 1'b1;
               state_d   = S_BR_WAIT;
            end
         end
         S_LOAD_STALL: begin
            stallIfid = 1'b1;
            stallIdex = 1'b1;
            bubbleEx  = 1'b1;
            cnt_d     = cnt_q - 3'd1;
            if (cnt_q <= 3'd1) begin
               state_d = S_IDLE;
            end
         end
         S_BR_WAIT: begin
            if (!hif.branch_resolved) begin
               stallIfid = 1'b1;
            end else if (hif.branch_taken) begin
               flushSig = 1'b1;
               if (FLUSH_LEN > 1) begin
                  state_d = S_FLUSH;
                  cnt_d   = 3'(FLUSH_LEN - 1);
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FLUSH: begin
            flushSig = 1'b1;
            cnt_d    = cnt_q - 3'd1;
            if (cnt_q <= 3'd1) begin
               state_d = S_IDLE;
            end
         end
`ifdef HAZARD_MULDIV_EN
         S_MD_BUSY: begin
            if (hif.md_done) begin
               state_d = S_IDLE;
            end else begin
               stallIfid  = 1'b1;
               stallIdex  = 1'b1;
               stallExmem = 1'b1;
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         stallCycles_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (stallIfid && (stallCycles_q != '1)) begin
            stallCycles_q <= stallCycles_q + CNT_W'(1);
         end
      end
   end

   // Reset masks every output in the same cycle so an abandoned operation leaves nothing behind.
   assign hif.stall_IFID   = stallIfid & ~reset;
   assign hif.stall_IDEX   = stallIdex & ~reset;
   assign hif.bubble_EX    = bubbleEx & ~reset;
   assign hif.flush        = flushSig & ~reset;
   assign hif.busy         = (state_q != S_IDLE) & ~reset;
   assign hif.stall_cycles = reset ? '0 : stallCycles_q;
`ifdef HAZARD_MULDIV_EN
   assign hif.stall_EXMEM  = stallExmem & ~reset;
`else
   assign hif.stall_EXMEM  = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (LOAD_STALL=3, FLUSH_LEN=2, CNT_W=3 so counter saturation is reachable).
// Stimulus pushes hand-computed per-cycle expectations; a negedge monitor pops and compares them.
module tb_pipeline_hazard_ctrl;

   typedef struct packed {
      logic       rst;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       wb;
      logic       ld;
      logic       brId;
      logic       brRes;
      logic       brTk;
      logic       mdS;
      logic       mdD;
   } stim_t;

   typedef struct {
      string      name;
      logic [5:0] ctrl;
      logic [2:0] cnt;
   } exp_t;

   // ctrl = {stall_IFID, stall_IDEX, stall_EXMEM, bubble_EX, flush, busy}
   localparam logic [5:0] E_NONE  = 6'b000000;
   localparam logic [5:0] E_BUSY  = 6'b000001;
   localparam logic [5:0] E_LOAD  = 6'b110100;
   localparam logic [5:0] E_LOADB = 6'b110101;
   localparam logic [5:0] E_BR    = 6'b100000;
   localparam logic [5:0] E_BRB   = 6'b100001;
   localparam logic [5:0] E_FLB   = 6'b000011;
   localparam logic [5:0] E_MD    = 6'b111000;
   localparam logic [5:0] E_MDB   = 6'b111001;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   exp_t expQ[$];

   pipeline_hazard_ctrl_if #(.REG_W(5), .CNT_W(3)) hif ();

   pipeline_hazard_ctrl #(
      .REG_W(5),
      .LOAD_STALL(3),
      .FLUSH_LEN(2),
      .CNT_W(3)
   ) dut (
      .clk(clk),
      .reset(reset),
      .hif(hif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input string name, input stim_t s, input logic [5:0] ctrl, input logic [2:0] cnt);
      exp_t e;
      @(posedge clk);
      #1;
      reset               = s.rst;
      hif.rs1_ID          = s.rs1;
      hif.rs2_ID          = s.rs2;
      hif.rs1_used_ID     = s.u1;
      hif.rs2_used_ID     = s.u2;
      hif.rd_EX           = s.rd;
      hif.reg_WB_EX       = s.wb;
      hif.load_EX         = s.ld;
      hif.branch_ID       = s.brId;
      hif.branch_resolved = s.brRes;
      hif.branch_taken    = s.brTk;
      hif.md_start_EX     = s.mdS;
      hif.md_done         = s.mdD;
      e.name = name;
      e.ctrl = ctrl;
      e.cnt  = cnt;
      expQ.push_back(e);
   endtask

   task automatic checkOutput(input exp_t e);
      logic [5:0] actCtrl;
      actCtrl = {hif.stall_IFID, hif.stall_IDEX, hif.stall_EXMEM, hif.bubble_EX, hif.flush, hif.busy};
      checks++;
      if (actCtrl !== e.ctrl) begin
         failures++;
         $display("[TB] FAIL %s ctrl actual=%b required=%b", e.name, actCtrl, e.ctrl);
      end
      checks++;
      if (hif.stall_cycles !== e.cnt) begin
         failures++;
         $display("[TB] FAIL %s stall_cycles actual=%0d required=%0d", e.name, hif.stall_cycles, e.cnt);
      end
   endtask

   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         checkOutput(expQ.pop_front());
      end
   end

   function automatic stim_t luhStim(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                                     input logic u2, input logic [4:0] rd);
      stim_t s;
      s     = '0;
      s.ld  = 1'b1;
      s.wb  = 1'b1;
      s.rs1 = rs1;
      s.u1  = u1;
      s.rs2 = rs2;
      s.u2  = u2;
      s.rd  = rd;
      return s;
   endfunction

   initial begin
      stim_t s;
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      hif.rs1_ID = '0; hif.rs2_ID = '0; hif.rs1_used_ID = 1'b0; hif.rs2_used_ID = 1'b0;
      hif.rd_EX = '0; hif.reg_WB_EX = 1'b0; hif.load_EX = 1'b0; hif.branch_ID = 1'b0;
      hif.branch_resolved = 1'b0; hif.branch_taken = 1'b0; hif.md_start_EX = 1'b0; hif.md_done = 1'b0;

      s = luhStim(5'd0, 1'b0, 5'd5, 1'b1, 5'd5); s.rst = 1'b1; s.brId = 1'b1;
      applyStimulus("reset_masks_luh", s, E_NONE, 3'd0);
      s = '0; s.rst = 1'b1;
      applyStimulus("reset_hold", s, E_NONE, 3'd0);
      applyStimulus("post_reset", '0, E_NONE, 3'd0);

      applyStimulus("luh_rs2_c1", luhStim(5'd0, 1'b0, 5'd5, 1'b1, 5'd5), E_LOAD, 3'd0);
      applyStimulus("luh_rs2_c2", '0, E_LOADB, 3'd1);
      applyStimulus("luh_rs2_c3", '0, E_LOADB, 3'd2);
      applyStimulus("luh_done", '0, E_NONE, 3'd3);
      applyStimulus("luh_rs2_unused", luhStim(5'd5, 1'b0, 5'd5, 1'b0, 5'd5), E_NONE, 3'd3);
      applyStimulus("luh_rd_zero", luhStim(5'd0, 1'b1, 5'd0, 1'b1, 5'd0), E_NONE, 3'd3);
      s = luhStim(5'd5, 1'b1, 5'd5, 1'b1, 5'd5); s.wb = 1'b0;
      applyStimulus("luh_no_wb", s, E_NONE, 3'd3);

      s = '0; s.brId = 1'b1;
      applyStimulus("br_detect", s, E_BR, 3'd3);
      s = luhStim(5'd5, 1'b1, 5'd0, 1'b0, 5'd5); s.mdS = 1'b1;
      applyStimulus("br_wait_ignores", s, E_BRB, 3'd4);
      s = '0; s.brRes = 1'b1; s.brTk = 1'b1;
      applyStimulus("br_taken_flush1", s, E_FLB, 3'd5);
      s = luhStim(5'd5, 1'b1, 5'd0, 1'b0, 5'd5); s.brId = 1'b1;
      applyStimulus("flush2_ignores", s, E_FLB, 3'd5);
      applyStimulus("flush_done", '0, E_NONE, 3'd5);

      s = '0; s.brId = 1'b1;
      applyStimulus("br_nt_detect", s, E_BR, 3'd5);
      s = '0; s.brRes = 1'b1;
      applyStimulus("br_nt_resolve", s, E_BUSY, 3'd6);
      applyStimulus("br_nt_idle", '0, E_NONE, 3'd6);
      s = '0; s.brRes = 1'b1; s.brTk = 1'b1;
      applyStimulus("stray_resolve", s, E_NONE, 3'd6);

      applyStimulus("luh_rs1_c1", luhStim(5'd7, 1'b1, 5'd3, 1'b1, 5'd7), E_LOAD, 3'd6);
      applyStimulus("luh_rs1_c2", '0, E_LOADB, 3'd7);
      applyStimulus("cnt_saturate", '0, E_LOADB, 3'd7);
      applyStimulus("cnt_hold", '0, E_NONE, 3'd7);

      s = luhStim(5'd9, 1'b1, 5'd0, 1'b0, 5'd9); s.brId = 1'b1;
      applyStimulus("prio_luh_over_br", s, E_LOAD, 3'd7);
      applyStimulus("prio_c2", '0, E_LOADB, 3'd7);
      applyStimulus("prio_c3", '0, E_LOADB, 3'd7);
      applyStimulus("prio_br_dropped", '0, E_NONE, 3'd7);

`ifdef HAZARD_MULDIV_EN
      s = luhStim(5'd5, 1'b1, 5'd0, 1'b0, 5'd5); s.mdS = 1'b1;
      applyStimulus("md_start_over_luh", s, E_MD, 3'd7);
      for (int i = 0; i < 4; i++) begin
         applyStimulus("md_busy", '0, E_MDB, 3'd7);
      end
      s = '0; s.mdD = 1'b1;
      applyStimulus("md_done", s, E_BUSY, 3'd7);
      applyStimulus("md_idle", '0, E_NONE, 3'd7);
      s = '0; s.mdS = 1'b1; s.mdD = 1'b1;
      applyStimulus("md_start_and_done", s, E_NONE, 3'd7);
      applyStimulus("md_no_residue", '0, E_NONE, 3'd7);
`else
      s = '0; s.mdS = 1'b1;
      applyStimulus("md_ignored", s, E_NONE, 3'd7);
      s = luhStim(5'd5, 1'b1, 5'd0, 1'b0, 5'd5); s.mdS = 1'b1;
      applyStimulus("md_off_luh_c1", s, E_LOAD, 3'd7);
      applyStimulus("md_off_luh_c2", '0, E_LOADB, 3'd7);
      applyStimulus("md_off_luh_c3", '0, E_LOADB, 3'd7);
      applyStimulus("md_off_idle", '0, E_NONE, 3'd7);
`endif

      s = '0; s.brId = 1'b1;
      applyStimulus("rst_br_detect", s, E_BR, 3'd7);
      s = '0; s.brRes = 1'b1; s.brTk = 1'b1;
      applyStimulus("rst_flush1", s, E_FLB, 3'd7);
      s = '0; s.rst = 1'b1;
      applyStimulus("rst_in_flush2", s, E_NONE, 3'd0);
      applyStimulus("rst_after_idle", '0, E_NONE, 3'd0);
      applyStimulus("rst_luh_c1", luhStim(5'd4, 1'b1, 5'd0, 1'b0, 5'd4), E_LOAD, 3'd0);
      applyStimulus("rst_luh_c2", '0, E_LOADB, 3'd1);
      applyStimulus("rst_luh_c3", '0, E_LOADB, 3'd2);
      applyStimulus("rst_luh_done", '0, E_NONE, 3'd3);

      for (int i = 0; i < 5 && expQ.size() > 0; i++) begin
         @(negedge clk);
      end
      #1;
      checks++;
      if (expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_drain pending=%0d required=0", expQ.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Sequential hazard controller for the 5-stage RISC-V pipeline, sitting beside the ID/EX decode logic and driving the stall, bubble and flush controls of the IF/ID, ID/EX and EX/MEM pipeline registers. It generalises the combinational load-use/branch hazard logic:
- multi-cycle load-use stalls set by parameter;
- a branch-wait state machine held until resolution;
- multi-cycle flush after a taken branch;
- operand-use qualification;
- an optional multi-cycle EX-unit (mul/div) busy stall;
- a saturating stall-cycle counter.

## Interface
Parameters:
- REG_W, 5, register address width
- LOAD_STALL, 1, stall cycles per load-use hazard (1..7)
- FLUSH_LEN, 1, flush cycles after taken branch (1..7)
- CNT_W, 16, width of stall-cycle counter

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- rs1_ID, rs2_ID  in  REG_W  source registers of instruction in ID
- rs1_used_ID, rs2_used_ID  in  1  instruction in ID actually reads rs1/rs2
- rd_EX  in  REG_W  destination of instruction in EX
- reg_WB_EX  in  1  EX instruction writes rd
- load_EX  in  1  EX instruction is a load
- branch_ID  in  1  branch/jump decoded in ID
- branch_resolved  in  1  branch outcome valid this cycle
- branch_taken  in  1  outcome, qualified by branch_resolved
- md_start_EX  in  1  multi-cycle op entered EX
- md_done  in  1  multi-cycle op result ready
- stall_IFID, stall_IDEX, stall_EXMEM  out  1  hold respective register
- bubble_EX  out  1  load NOP into ID/EX
- flush  out  1  squash IF/ID and ID/EX
- busy  out  1  FSM not in IDLE
- stall_cycles  out  CNT_W  cycles with stall_IFID=1, saturating

## Operation
- Hazard conditions:
  - Load-use hazard (luh) = load_EX & reg_WB_EX & rd_EX!=0 & ((rs1_used_ID & rs1_ID==rd_EX) | (rs2_used_ID & rs2_ID==rd_EX)).
- FSM states: IDLE, LOAD_STALL, BR_WAIT, FLUSH, MD_BUSY. Counter cnt (3 bits) used by LOAD_STALL and FLUSH.
- IDLE, evaluated in priority order:
  1. md_start_EX & !md_done: assert stall_IFID, stall_IDEX, stall_EXMEM; go to MD_BUSY.
  2. luh: assert stall_IFID, stall_IDEX, bubble_EX. If LOAD_STALL>1, go to LOAD_STALL with cnt=LOAD_STALL-1; otherwise stay in IDLE.
  3. branch_ID: assert stall_IFID; go to BR_WAIT.
  4. Otherwise all outputs 0.
- LOAD_STALL: assert stall_IFID, stall_IDEX, bubble_EX. Decrement cnt; return to IDLE when cnt==1. Inputs are ignored.
- BR_WAIT:
  - branch_resolved=0: assert stall_IFID.
  - branch_resolved & branch_taken: assert flush, with stall_IFID=0. If FLUSH_LEN>1, go to FLUSH with cnt=FLUSH_LEN-1; otherwise go to IDLE.
  - branch_resolved & !branch_taken: all outputs 0; go to IDLE.
- FLUSH: assert flush. Decrement cnt; return to IDLE when cnt==1. branch_ID and luh are ignored.
- MD_BUSY: assert stall_IFID, stall_IDEX, stall_EXMEM until md_done=1. In the md_done cycle all stalls are 0 and the FSM returns to IDLE.
- busy=1 whenever state!=IDLE.
- stall_cycles increments on every cycle with stall_IFID=1 and holds at 2^CNT_W-1.

## Timing
- reset=1: all outputs forced 0 combinationally in that cycle. At the next edge: state=IDLE, cnt=0, stall_cycles=0.
- Reset mid-operation (any state) abandons the operation with no residual stall or flush.
- First-cycle response in IDLE is combinational (same cycle as detection). Subsequent cycles come from registered state.
- Load-use hazard: stall_IFID is high for exactly LOAD_STALL consecutive cycles.
- Taken branch: flush is high for exactly FLUSH_LEN consecutive cycles, starting in the resolve cycle.
- Simultaneous events in IDLE follow the priority order above. Lower-priority events are not queued; upstream re-presents them, since ID is held.
- md_start_EX & md_done in the same IDLE cycle: no stall.
- In BR_WAIT, md_start_EX and luh are ignored, because EX holds the branch.

## Configuration
- HAZARD_MULDIV_EN defined: md_start_EX and md_done are active, and the MD_BUSY state exists.
- HAZARD_MULDIV_EN undefined:
  - ports are kept but ignored;
  - MD_BUSY is never entered;
  - stall_EXMEM is constant 0.

## Test plan
- Reset: drive luh inputs with reset=1 → all outputs 0. After release, stall_cycles=0 and busy=0.
- LOAD_STALL=3, load_EX=1, reg_WB_EX=1, rd_EX=5, rs2_ID=5, rs2_used_ID=1 → stall_IFID/stall_IDEX/bubble_EX high for 3 cycles, and stall_cycles=3. Repeat with rs2_used_ID=0, or with rd_EX=0 → no stall.
- branch_ID=1, then branch_resolved=1 & branch_taken=1 after 2 cycles, with FLUSH_LEN=2 → stall_IFID high 2 cycles, then flush high 2 cycles, then busy=0.
- Branch not taken → stall_IFID drops in the resolve cycle and flush is never asserted.
- With HAZARD_MULDIV_EN: md_start_EX, then md_done 5 cycles later → all three stalls high 5 cycles. luh asserted together with md_start_EX → only the MD stall occurs.
- Reset asserted in the second cycle of FLUSH → flush=0 immediately, and state is IDLE the next cycle.
